// File: rtl/jtdd_obj_linebuf.sv
// Double-banked object line buffer: the engine draws into one bank while the
// other is displayed and cleared pixel by pixel; the banks swap on HBL rise.
module jtdd_obj_linebuf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          HBL,
    input  logic [7:0]    HPOS,
    input  logic          wr_en,
    input  logic [7:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] obj_pxl,
    output logic          ready,
    output logic          line_start
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state;
    logic [8:0]    cnt;
    logic          rd_bank;
    logic          hbl_l;
    logic [DW-1:0] mem [0:511];   // {bank, x}

    logic hbl_rise;
    logic eng_we;
    logic clr_we;

    assign hbl_rise = pxl_cen & HBL & ~hbl_l;
    assign eng_we   = (state == RUN) && wr_en && (wr_data[3:0] != 4'd0);
    assign clr_we   = (state == RUN) && pxl_cen && !HBL;

    // NOTE: the buffer has no reset; the CLEAR sweep is what empties it, so it
    // can map onto RAM and a reset never has to touch 512 words at once.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            // Draw and read-and-clear always hit opposite banks.
            if (eng_we) mem[{~rd_bank, wr_addr}] <= wr_data;
            if (clr_we) mem[{rd_bank, HPOS}]     <= '0;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every read
    // below sees the pre-edge value, e.g. the write bank on a swap clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            cnt        <= '0;
            rd_bank    <= 1'b0;
            hbl_l      <= 1'b1;
            obj_pxl    <= '0;
            ready      <= 1'b0;
            line_start <= 1'b0;
        end else begin
            line_start <= 1'b0;
            if (state == CLEAR) begin
                obj_pxl <= '0;
                cnt     <= cnt + 9'd1;
                if (cnt == 9'd511) begin
                    state <= RUN;
                    ready <= 1'b1;
                end
            end else if (pxl_cen) begin
                hbl_l   <= HBL;
                obj_pxl <= HBL ? '0 : mem[{rd_bank, HPOS}];
                if (hbl_rise) begin
                    rd_bank    <= ~rd_bank;
                    line_start <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtdd_obj_linebuf.sv
// Bench for jtdd_obj_linebuf: two-bank line model checked every clk plus
// directed line scenarios with literal expectations.
module tb_jtdd_obj_linebuf;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen = 1'b0;
    logic       HBL = 1'b1;
    logic [7:0] HPOS = '0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] obj_pxl;
    logic       ready;
    logic       line_start;

    jtdd_obj_linebuf #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pxl_cen    (pxl_cen),
        .HBL        (HBL),
        .HPOS       (HPOS),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .obj_pxl    (obj_pxl),
        .ready      (ready),
        .line_start (line_start)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: two line arrays; display side is drained as it is shown.
    logic [7:0] mb [0:1][0:255];
    int         m_clks;
    int         m_rd;
    logic       m_hprev;
    logic [7:0] exp_pxl;
    logic       exp_ready;
    logic       exp_ls;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clks    <= 0;
            m_rd      <= 0;
            m_hprev   <= 1'b1;
            exp_pxl   <= '0;
            exp_ready <= 1'b0;
            exp_ls    <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 256; a++) mb[b][a] <= '0;
        end else begin
            exp_ls <= 1'b0;
            if (m_clks < 512) begin
                m_clks <= m_clks + 1;
                if (m_clks == 511) exp_ready <= 1'b1;
            end else begin
                if (wr_en && wr_data[3:0] != 4'd0) mb[1 - m_rd][wr_addr] <= wr_data;
                if (pxl_cen) begin
                    m_hprev <= HBL;
                    if (HBL) begin
                        exp_pxl <= '0;
                        if (!m_hprev) begin
                            m_rd   <= 1 - m_rd;
                            exp_ls <= 1'b1;
                        end
                    end else begin
                        exp_pxl        <= mb[m_rd][HPOS];
                        mb[m_rd][HPOS] <= '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("obj_pxl", 32'(obj_pxl), 32'(exp_pxl));
            check("ready", 32'(ready), 32'(exp_ready));
            check("line_start", 32'(line_start), 32'(exp_ls));
        end
    end

    // Directed stimulus helpers
    logic [7:0] wq_a [$];
    logic [7:0] wq_d [$];
    logic [7:0] seen [0:255];
    int         ls_cnt;

    task automatic step(input logic cen, input logic hbl, input logic [7:0] hp, input bit rnd,
                        input bit fw, input logic [7:0] fa, input logic [7:0] fd);
        pxl_cen = cen;
        HBL     = hbl;
        HPOS    = hp;
        wr_en   = 1'b0;
        wr_addr = 8'($urandom);
        wr_data = 8'($urandom);
        if ($urandom_range(0, 3) == 0) wr_data[3:0] = 4'd0;
        if (fw) begin
            wr_en = 1'b1; wr_addr = fa; wr_data = fd;
        end else if (wq_a.size() > 0) begin
            wr_en = 1'b1; wr_addr = wq_a.pop_front(); wr_data = wq_d.pop_front();
        end else if (rnd && $urandom_range(0, 2) == 0) begin
            wr_en = 1'b1;
        end
        @(posedge clk);
        #1;
        if (line_start) ls_cnt++;
    endtask

    task automatic run_line(input bit rnd, input bit sw, input logic [7:0] sa, input logic [7:0] sd);
        ls_cnt = 0;
        for (int h = 0; h < 256; h++) begin
            step(1'b1, 1'b0, 8'(h), rnd, 1'b0, 8'd0, 8'd0);
            seen[h] = obj_pxl;
            step(1'b0, 1'b0, 8'(h), rnd, 1'b0, 8'd0, 8'd0);
        end
        for (int b = 0; b < 8; b++)
            step((b % 2) == 0, 1'b1, 8'd0, rnd, sw && (b == 0), sa, sd);
        check("line_start pulses per line", 32'(ls_cnt), 32'd1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 600) begin
            step((n % 2) == 0, 1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0);
            n++;
        end
        check("clks until ready", 32'(n), 32'd512);
    endtask

    function automatic int count_nz(input int s0, input int s1, input int s2);
        int c;
        c = 0;
        for (int h = 0; h < 256; h++)
            if (h != s0 && h != s1 && h != s2 && seen[h] != 8'd0) c++;
        return c;
    endfunction

    task automatic push_w(input logic [7:0] a, input logic [7:0] d);
        wq_a.push_back(a);
        wq_d.push_back(d);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(ready), 32'd0);
        check("reset obj_pxl", 32'(obj_pxl), 32'd0);
        rst = 1'b0;
        wait_ready();

        // First line shows an empty bank; its writes land in the other bank.
        push_w(8'd10, 8'h35);
        push_w(8'd200, 8'h07);
        run_line(1'b0, 1'b0, 8'd0, 8'd0);
        check("first line nonzero pixels", 32'(count_nz(-1, -1, -1)), 32'd0);

        push_w(8'd50, 8'h41);
        push_w(8'd50, 8'h20);
        run_line(1'b0, 1'b0, 8'd0, 8'd0);
        check("pixel @10", 32'(seen[10]), 32'h35);
        check("pixel @200", 32'(seen[200]), 32'h07);
        check("other pixels", 32'(count_nz(10, 200, -1)), 32'd0);

        push_w(8'd50, 8'h42);
        run_line(1'b0, 1'b1, 8'd5, 8'h11);
        check("cleared @10", 32'(seen[10]), 32'd0);
        check("cleared @200", 32'(seen[200]), 32'd0);
        check("opaque kept over transparent", 32'(seen[50]), 32'h41);

        run_line(1'b0, 1'b0, 8'd0, 8'd0);
        check("later opaque overwrites", 32'(seen[50]), 32'h42);
        check("write on swap clk", 32'(seen[5]), 32'h11);
        check("only two pixels", 32'(count_nz(50, 5, -1)), 32'd0);

        for (int i = 0; i < 4; i++) run_line(1'b1, 1'b0, 8'd0, 8'd0);

        // Reset mid-line with data pending in both banks.
        push_w(8'd150, 8'h55);
        run_line(1'b1, 1'b0, 8'd0, 8'd0);
        push_w(8'd200, 8'h66);
        for (int h = 0; h < 100; h++) begin
            step(1'b1, 1'b0, 8'(h), 1'b1, 1'b0, 8'd0, 8'd0);
            step(1'b0, 1'b0, 8'(h), 1'b1, 1'b0, 8'd0, 8'd0);
        end
        rst = 1'b1;
        #1;
        check("mid-line reset obj_pxl", 32'(obj_pxl), 32'd0);
        check("mid-line reset ready", 32'(ready), 32'd0);
        check("mid-line reset line_start", 32'(line_start), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready();
        run_line(1'b0, 1'b0, 8'd0, 8'd0);
        check("post-reset line A nonzero", 32'(count_nz(-1, -1, -1)), 32'd0);
        run_line(1'b0, 1'b0, 8'd0, 8'd0);
        check("post-reset line B nonzero", 32'(count_nz(-1, -1, -1)), 32'd0);
        run_line(1'b1, 1'b0, 8'd0, 8'd0);
        run_line(1'b1, 1'b0, 8'd0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
